// File: rtl/axi_arb_pkg.sv
// AXI read-channel widths and the types shared by the ROM read arbiter and its
// round-robin picker.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`define AXI_LEN_BITS 4
`define AXI_SIZE_BITS 3
`define AXI_ID_BITS 4
`define AXI_IDS_BITS 8
`endif

package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Grant index of each master; also the routing bit carried in the slave-side ID.
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = GNT_M0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = GNT_M1;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Two-master AXI read arbiter in front of the boot ROM: round-robin grant held for
// a whole burst, combinational AR/R forwarding, sticky RLAST position check.
module rom_read_arbiter
    import axi_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]                ARBURST_M0,
    input  logic                      ARVALID_M0,
    output logic                      ARREADY_M0,
    output logic [`AXI_ID_BITS-1:0]   RID_M0,
    output logic [`AXI_DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]                RRESP_M0,
    output logic                      RLAST_M0,
    output logic                      RVALID_M0,
    input  logic                      RREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]                ARBURST_M1,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M1,
    output logic [`AXI_ID_BITS-1:0]   RID_M1,
    output logic [`AXI_DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]                RRESP_M1,
    output logic                      RLAST_M1,
    output logic                      RVALID_M1,
    input  logic                      RREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]  ARID_S,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_S,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]                ARBURST_S,
    output logic                      ARVALID_S,
    input  logic                      ARREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]  RID_S,
    input  logic [`AXI_DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]                RRESP_S,
    input  logic                      RLAST_S,
    input  logic                      RVALID_S,
    output logic                      RREADY_S,
    output logic                      rlast_err,
    output arb_state_t                state_dbg
);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are
    // both high; VALID never depends on READY and holds its payload until taken.

    localparam int                     PAD_BITS = `AXI_IDS_BITS - `AXI_ID_BITS - 1;
    localparam logic [`AXI_LEN_BITS-1:0] BEAT_ONE = 1;

    arb_state_t               state_q, state_d;
    logic                     grant_q, last_grant_q, pick;
    logic [`AXI_LEN_BITS-1:0] beat_cnt_q, len_q;
    logic                     rlast_err_q;
    logic                     ar_hs, r_hs, rid_bad;
    logic                     unused_rid_hi;

    rr_arbiter2 u_rr (
        .req        ({ARVALID_M1, ARVALID_M0}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    assign ar_hs         = (state_q == ADDR) && ARVALID_S && ARREADY_S;
    assign r_hs          = (state_q == DATA) && RVALID_S && RREADY_S;
    assign rid_bad       = (state_q == DATA) && RVALID_S && (RID_S[`AXI_ID_BITS] != grant_q);
    assign unused_rid_hi = ^RID_S[`AXI_IDS_BITS-1:`AXI_ID_BITS+1];
    assign rlast_err     = rlast_err_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ARVALID_M0 || ARVALID_M1) state_d = ADDR;
            ADDR:    if (ar_hs) state_d = DATA;
            DATA:    if (r_hs && RLAST_S) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // AR/R muxing; everything not owned by the current grant is driven to zero.
    always_comb begin
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        RREADY_S   = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        if (state_q == ADDR) begin
            if (grant_q == GNT_M1) begin
                ARID_S     = {{PAD_BITS{1'b0}}, GNT_M1, ARID_M1};
                ARADDR_S   = ARADDR_M1;
                ARLEN_S    = ARLEN_M1;
                ARSIZE_S   = ARSIZE_M1;
                ARBURST_S  = ARBURST_M1;
                ARVALID_S  = ARVALID_M1;
                ARREADY_M1 = ARREADY_S;
            end else begin
                ARID_S     = {{PAD_BITS{1'b0}}, GNT_M0, ARID_M0};
                ARADDR_S   = ARADDR_M0;
                ARLEN_S    = ARLEN_M0;
                ARSIZE_S   = ARSIZE_M0;
                ARBURST_S  = ARBURST_M0;
                ARVALID_S  = ARVALID_M0;
                ARREADY_M0 = ARREADY_S;
            end
        end
        if (state_q == DATA) begin
            // A stray RID routing bit is flagged, but data still follows the grant.
            if (grant_q == GNT_M1) begin
                RREADY_S  = RREADY_M1;
                RID_M1    = RID_S[`AXI_ID_BITS-1:0];
                RDATA_M1  = RDATA_S;
                RRESP_M1  = RRESP_S;
                RLAST_M1  = RLAST_S;
                RVALID_M1 = RVALID_S;
            end else begin
                RREADY_S  = RREADY_M0;
                RID_M0    = RID_S[`AXI_ID_BITS-1:0];
                RDATA_M0  = RDATA_S;
                RRESP_M0  = RRESP_S;
                RLAST_M0  = RLAST_S;
                RVALID_M0 = RVALID_S;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_M0;
            last_grant_q <= GNT_M1;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            rlast_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (ARVALID_M0 || ARVALID_M1)) begin
                grant_q <= pick;
            end
            if (ar_hs) begin
                len_q      <= ARLEN_S;
                beat_cnt_q <= '0;
            end
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                if (RLAST_S != (beat_cnt_q == len_q)) begin
                    rlast_err_q <= 1'b1;
                end
                if (RLAST_S) begin
                    last_grant_q <= grant_q;
                end
            end
            if (rid_bad) begin
                rlast_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomized bench for rom_read_arbiter: two random masters, a random-latency ROM
// model, and a transaction-level reference for grant order, routing and RLAST errors.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`define AXI_LEN_BITS 4
`define AXI_SIZE_BITS 3
`define AXI_ID_BITS 4
`define AXI_IDS_BITS 8
`endif

module tb_rom_read_arbiter;
    import axi_arb_pkg::*;

    localparam int M_IDLE      = 0;
    localparam int M_GRANT     = 1;
    localparam int M_BURST     = 2;
    localparam int FAULT_CYC   = 1200;
    localparam int RESET_CYC   = 1700;
    localparam int TRAFFIC_END = 2400;
    localparam int CYCLE_LIMIT = 3400;

    logic clk, rst;
    logic [`AXI_ID_BITS-1:0]   ARID_M0, ARID_M1, RID_M0, RID_M1;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_M0, ARLEN_M1, ARLEN_S;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
    logic [1:0]                ARBURST_M0, ARBURST_M1, ARBURST_S;
    logic                      ARVALID_M0, ARVALID_M1, ARVALID_S;
    logic                      ARREADY_M0, ARREADY_M1, ARREADY_S;
    logic [`AXI_DATA_BITS-1:0] RDATA_M0, RDATA_M1, RDATA_S;
    logic [1:0]                RRESP_M0, RRESP_M1, RRESP_S;
    logic                      RLAST_M0, RLAST_M1, RLAST_S;
    logic                      RVALID_M0, RVALID_M1, RVALID_S;
    logic                      RREADY_M0, RREADY_M1, RREADY_S;
    logic [`AXI_IDS_BITS-1:0]  ARID_S, RID_S;
    logic                      rlast_err;
    arb_state_t                state_dbg;

    rom_read_arbiter dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .rlast_err(rlast_err), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench state ----------------
    int n_checks, n_bad;

    logic        m_active [2];
    logic [31:0] m_addr   [2];
    logic [3:0]  m_len    [2];
    logic [3:0]  m_id     [2];
    logic [2:0]  m_size   [2];
    logic [1:0]  m_burst  [2];
    logic        m_rready [2];

    logic        s_busy, s_rvalid, s_arready;
    logic [31:0] s_addr;
    logic [7:0]  s_id;
    int          s_beat, s_last;

    int          mst, w, last_served, burst_beats, burst_len;
    logic [3:0]  burst_id;
    logic        err_exp;
    logic [34:0] exp_q[$];   // {rresp, last, data} per beat of the burst in flight

    logic allow_req, force_tie, inject_early, reset_done, drained;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic apply_inputs();
        ARVALID_M0 = m_active[0]; ARID_M0 = m_id[0]; ARADDR_M0 = m_addr[0];
        ARLEN_M0 = m_len[0]; ARSIZE_M0 = m_size[0]; ARBURST_M0 = m_burst[0];
        RREADY_M0 = m_rready[0];
        ARVALID_M1 = m_active[1]; ARID_M1 = m_id[1]; ARADDR_M1 = m_addr[1];
        ARLEN_M1 = m_len[1]; ARSIZE_M1 = m_size[1]; ARBURST_M1 = m_burst[1];
        RREADY_M1 = m_rready[1];
        ARREADY_S = s_arready;
        RVALID_S  = s_rvalid;
        RID_S     = s_rvalid ? s_id : 8'h00;
        RDATA_S   = s_rvalid ? rom_word(s_addr + 32'(4 * s_beat)) : 32'h0;
        RRESP_S   = s_rvalid ? 2'(s_beat) : 2'b00;
        RLAST_S   = s_rvalid && (s_beat == s_last);
    endtask

    task automatic drive_inputs();
        for (int x = 0; x < 2; x++) begin
            if (!m_active[x] && allow_req && (force_tie || $urandom_range(0, 99) < 60)) begin
                m_active[x] = 1'b1;
                m_addr[x]   = $urandom & 32'h0000_0FFC;
                m_len[x]    = 4'($urandom_range(0, 15));
                m_id[x]     = 4'($urandom_range(0, 15));
                m_size[x]   = 3'($urandom_range(0, 2));
                m_burst[x]  = 2'($urandom_range(0, 2));
            end
            m_rready[x] = ($urandom_range(0, 99) < 75);
        end
        force_tie = 1'b0;
        s_arready = !s_busy && ($urandom_range(0, 1) == 1);
        if (s_busy && !s_rvalid && $urandom_range(0, 99) < 70) s_rvalid = 1'b1;
        apply_inputs();
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_ar_s"}, {ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}, 64'h0);
        check_eq({pfx, "_ar_ready"}, {ARREADY_M0, ARREADY_M1, RREADY_S}, 64'h0);
        check_eq({pfx, "_r_m0"}, {RVALID_M0, RLAST_M0, RRESP_M0, RID_M0, RDATA_M0}, 64'h0);
        check_eq({pfx, "_r_m1"}, {RVALID_M1, RLAST_M1, RRESP_M1, RID_M1, RDATA_M1}, 64'h0);
        check_eq({pfx, "_rlast_err"}, rlast_err, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int x = 0; x < 2; x++) begin
            m_active[x] = 1'b0;
            m_rready[x] = 1'b0;
        end
        s_busy = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0; s_beat = 0; s_last = 0;
        apply_inputs();
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        mst = M_IDLE; last_served = 1; err_exp = 1'b0; burst_beats = 0;
        exp_q.delete();
    endtask

    // ---------------- monitor / reference model / scoreboard ----------------
    task automatic observe();
        logic        arr_w, arr_o, rv_w, rv_o, rl_w, take;
        logic [31:0] rd_w, rd_o;
        logic [3:0]  rid_w;
        logic [1:0]  rr_w;
        logic [34:0] e;
        arr_w = w ? ARREADY_M1 : ARREADY_M0;
        arr_o = w ? ARREADY_M0 : ARREADY_M1;
        rv_w  = w ? RVALID_M1 : RVALID_M0;
        rv_o  = w ? RVALID_M0 : RVALID_M1;
        rd_w  = w ? RDATA_M1 : RDATA_M0;
        rd_o  = w ? RDATA_M0 : RDATA_M1;
        rl_w  = w ? RLAST_M1 : RLAST_M0;
        rid_w = w ? RID_M1 : RID_M0;
        rr_w  = w ? RRESP_M1 : RRESP_M0;

        check_eq("rlast_err", rlast_err, err_exp);
        case (mst)
            M_IDLE: begin
                check_eq("idle_state", state_dbg, IDLE);
                check_eq("idle_ar", {ARVALID_S, ARREADY_M0, ARREADY_M1}, 64'h0);
                check_eq("idle_r", {RVALID_M0, RVALID_M1, RREADY_S}, 64'h0);
                if (m_active[0] || m_active[1]) begin
                    if (m_active[0] && m_active[1]) w = 1 - last_served;
                    else w = m_active[1] ? 1 : 0;
                    mst = M_GRANT;
                end
            end
            M_GRANT: begin
                check_eq("ar_valid", ARVALID_S, 1'b1);
                check_eq("ar_id", ARID_S, {3'b000, w[0], m_id[w]});
                check_eq("ar_addr", ARADDR_S, m_addr[w]);
                check_eq("ar_ctl", {ARLEN_S, ARSIZE_S, ARBURST_S}, {m_len[w], m_size[w], m_burst[w]});
                check_eq("ar_ready_gnt", arr_w, s_arready);
                check_eq("ar_ready_other", arr_o, 1'b0);
                check_eq("grant_r_quiet", {RVALID_M0, RVALID_M1, RREADY_S}, 64'h0);
                if (ARVALID_S && s_arready) begin
                    s_busy = 1'b1; s_rvalid = 1'b0; s_beat = 0;
                    s_addr = ARADDR_S; s_id = ARID_S; s_last = int'(ARLEN_S);
                    if (inject_early && ARLEN_S != 0) begin
                        s_last = $urandom_range(0, int'(ARLEN_S) - 1);
                        inject_early = 1'b0;
                    end
                end
                if (arr_w && m_active[w]) begin
                    for (int i = 0; i <= s_last; i++) begin
                        exp_q.push_back({2'(i), (i == s_last), rom_word(m_addr[w] + 32'(4 * i))});
                    end
                    burst_len   = int'(m_len[w]);
                    burst_id    = m_id[w];
                    burst_beats = 0;
                    m_active[w] = 1'b0;
                    mst = M_BURST;
                end
            end
            default: begin
                check_eq("burst_ar_quiet", {ARVALID_S, ARREADY_M0, ARREADY_M1}, 64'h0);
                check_eq("r_valid_gnt", rv_w, s_rvalid);
                check_eq("r_other_quiet", {rv_o, rd_o}, 64'h0);
                check_eq("r_ready_s", RREADY_S, m_rready[w]);
                take = rv_w && m_rready[w];
                if (s_rvalid && RREADY_S) begin
                    if (s_beat == s_last) s_busy = 1'b0;
                    else s_beat++;
                    s_rvalid = 1'b0;
                end
                if (take) begin
                    check_eq("r_beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("r_data", rd_w, e[31:0]);
                        check_eq("r_last", rl_w, e[32]);
                        check_eq("r_resp", rr_w, e[34:33]);
                        check_eq("r_id", rid_w, burst_id);
                        if (e[32]) begin
                            if (burst_beats != burst_len) err_exp = 1'b1;
                            last_served = w;
                            mst = M_IDLE;
                        end
                        burst_beats++;
                    end
                end
            end
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_bad = 0;
        for (int x = 0; x < 2; x++) begin
            m_active[x] = 1'b0; m_addr[x] = '0; m_len[x] = '0; m_id[x] = '0;
            m_size[x] = '0; m_burst[x] = '0; m_rready[x] = 1'b0;
        end
        s_addr = '0; s_id = '0; w = 0; burst_len = 0; burst_id = '0;
        inject_early = 1'b0; reset_done = 1'b0; drained = 1'b0; allow_req = 1'b1;
        do_reset(3);
        force_tie = 1'b1;
        for (int cyc = 0; cyc < CYCLE_LIMIT; cyc++) begin
            @(negedge clk);
            if (cyc == FAULT_CYC) inject_early = 1'b1;
            if (!reset_done && cyc >= RESET_CYC && mst == M_BURST && burst_beats >= 1) begin
                do_reset(1);
                force_tie  = 1'b1;
                reset_done = 1'b1;
            end
            allow_req = (cyc < TRAFFIC_END);
            if (cyc >= TRAFFIC_END && mst == M_IDLE && !m_active[0] && !m_active[1] && !s_busy) begin
                drained = 1'b1;
                break;
            end
            drive_inputs();
            #1;
            observe();
        end
        check_eq("drain_timeout", drained, 1'b1);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
